multi_rem_sys: RTL and testbench
================================

// Module: multi_rem_sys
// PURPOSE
//  Multi-channel reminder timer.
//  - NCH independent countdown channels; each is armed with a duration and a mode (one-shot or periodic).
//  - On expiry a channel raises a sticky notification that holds until acknowledged.
//  - A fixed-priority encoder reports the lowest pending channel to the host/alert logic.
// PARAMETERS
//  NCH  4                 number of reminder channels (>=2)
//  CW   32                duration/counter width in bits
//  IDW  $clog2(NCH)       channel index width (derived, do not override)
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    reset, asynchronous, active-high
//  set          in   1    arm request for channel set_ch, sampled at posedge
//  set_ch       in   IDW  channel to arm
//  dur          in   CW   duration in clk cycles for the armed channel
//  periodic     in   1    mode for the armed channel: 1=periodic, 0=one-shot
//  cancel       in   1    disarm request for channel cancel_ch
//  cancel_ch    in   IDW  channel to disarm
//  ack          in   1    acknowledge request for channel ack_ch
//  ack_ch       in   IDW  channel to acknowledge
//  busy         out  NCH  channel armed (WAIT or PEND state)
//  notif        out  NCH  sticky per-channel notification
//  missed       out  NCH  periodic channel expired again while notif was still 1
//  irq          out  1    one-cycle pulse on the cycle any notif goes 0->1
//  alert_valid  out  1    |notif
//  alert_ch     out  IDW  lowest index i with notif[i]=1; 0 when none
// BEHAVIOUR
//  Reset: all channels IDLE; busy, notif, missed, irq = 0; counters, stored dur and mode = 0.
//  Per-channel state: IDLE, WAIT (counting), PEND (one-shot expired, waiting for ack).
//  Per-channel registers: cnt[CW], rld[CW] (stored dur), mode bit.
//  Arm (set=1, set_ch<NCH, dur!=0):
//   - rld<=dur, cnt<=dur, mode<=periodic, state<=WAIT.
//   - notif and missed are cleared.
//   - Arming a busy channel restarts it with the new values.
//  Ignored requests:
//   - set with dur==0, or any request with a channel index >=NCH, is ignored (no state change).
//  Countdown in WAIT:
//   - cnt decrements by 1 each cycle.
//   - The edge at which cnt==1 is the expiry edge: notif<=1.
//   - Result: set sampled at edge E0 gives notif=1 after edge E0+D. dur=1 gives notif after E0+1.
//  Expiry:
//   - one-shot: state<=PEND, cnt holds.
//   - periodic: cnt<=rld, stays WAIT. If notif was already 1 and is not acked that cycle, missed<=1.
//  ack on a channel:
//   - Clears notif and missed.
//   - PEND -> IDLE; WAIT stays WAIT; ack on an IDLE channel is a no-op.
//  cancel on a channel: state<=IDLE; notif, missed and cnt cleared.
//  Same-channel, same-cycle priority: cancel > set > ack/expiry.
//   - ack and expiry in the same cycle: notif stays 1, missed is 0.
//  Requests that target different channels in the same cycle all take effect independently.
//  Output timing:
//   - irq is registered: 1 for exactly one cycle after any edge where some notif bit rises.
//   - busy = (state!=IDLE); alert_valid and alert_ch are combinational from the notif register.
//  Width rules:
//   - All arithmetic is CW bits.
//   - No wrap: cnt never decrements below 1 while in WAIT.
//  Reset mid-countdown aborts immediately to the reset values. No notification is produced.
// TESTING
//  1. Arm ch0 dur=5 one-shot at edge 0 -> notif[0]=1 after edge 5, irq pulses 1 cycle, alert_ch=0; ack -> notif[0]=0, busy[0]=0.
//  2. Arm ch2 dur=3 periodic, never ack -> notif[2] after edges 3; missed[2] after edge 6; ack at edge 7 clears both, next notif after edge 9.
//  3. Arm ch1 dur=4 and ch3 dur=2 -> alert_ch=3 after edge 2, then 1 once ch1 expires; ack ch1 -> alert_ch=3.
//  4. Arm ch0 dur=0, or set_ch >= NCH -> no change; re-arm busy ch0 dur=8 mid-count -> expiry after edge reset +8.
//  5. Same cycle on ch1: cancel+set+ack -> ch1 IDLE. Separately, ack on the expiry edge of periodic ch1 -> notif[1]=1, missed[1]=0.
//  6. Assert rst while ch0 and ch2 are counting -> all outputs 0 immediately; no notif after release without re-arm.

Source files
------------

// File: rtl/multi_rem_sys.sv
// Multi-channel reminder timer.
// Each of NCH channels counts down an armed duration (one-shot or periodic),
// raises a sticky notification on expiry, and a fixed-priority encoder reports
// the lowest pending channel.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   set/set_ch/dur/periodic   arm request: channel, duration, mode
//   cancel/cancel_ch          disarm request
//   ack/ack_ch                acknowledge request
//   busy[NCH]                 channel in WAIT or PEND
//   notif[NCH]                sticky expiry notification
//   missed[NCH]               periodic expiry while notif still pending
//   irq                       one-cycle pulse after any notif bit rises
//   alert_valid, alert_ch     |notif and lowest pending channel index
module multi_rem_sys #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32,
  localparam int unsigned IDW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set,
  input  logic [IDW-1:0] set_ch,
  input  logic [CW-1:0]  dur,
  input  logic           periodic,
  input  logic           cancel,
  input  logic [IDW-1:0] cancel_ch,
  input  logic           ack,
  input  logic [IDW-1:0] ack_ch,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] notif,
  output logic [NCH-1:0] missed,
  output logic           irq,
  output logic           alert_valid,
  output logic [IDW-1:0] alert_ch
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t         r_state     [NCH];
  state_t         w_state_nxt [NCH];
  logic [CW-1:0]  r_cnt       [NCH];
  logic [CW-1:0]  w_cnt_nxt   [NCH];
  logic [CW-1:0]  r_rld       [NCH];
  logic [CW-1:0]  w_rld_nxt   [NCH];
  logic [NCH-1:0] r_mode, w_mode_nxt;
  logic [NCH-1:0] r_notif, w_notif_nxt;
  logic [NCH-1:0] r_missed, w_missed_nxt;
  logic [NCH-1:0] r_busy, w_busy_nxt;
  logic           r_irq, w_irq_nxt;
  logic [NCH-1:0] w_cancel_hit, w_set_hit, w_ack_hit, w_expire;
  logic           w_dur_ok;

  assign w_dur_ok = (dur != '0);

  // Per-channel request decode; indices >= NCH match no channel and are dropped.
  always_comb begin
    w_cancel_hit = '0;
    w_set_hit    = '0;
    w_ack_hit    = '0;
    w_expire     = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cancel_hit[i] = cancel && (cancel_ch == IDW'(i));
      w_set_hit[i]    = set && w_dur_ok && (set_ch == IDW'(i));
      w_ack_hit[i]    = ack && (ack_ch == IDW'(i));
      w_expire[i]     = (r_state[i] == ST_WAIT) && (r_cnt[i] == CW'(1));
    end
  end

  // Next-state and output logic; priority cancel > set > ack/expiry.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_notif_nxt  = r_notif;
    w_missed_nxt = r_missed;
    w_busy_nxt   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_rld_nxt[i]   = r_rld[i];
      if (w_cancel_hit[i]) begin
        w_state_nxt[i]  = ST_IDLE;
        w_cnt_nxt[i]    = '0;
        w_notif_nxt[i]  = 1'b0;
        w_missed_nxt[i] = 1'b0;
      end else if (w_set_hit[i]) begin
        w_state_nxt[i]  = ST_WAIT;
        w_cnt_nxt[i]    = dur;
        w_rld_nxt[i]    = dur;
        w_mode_nxt[i]   = periodic;
        w_notif_nxt[i]  = 1'b0;
        w_missed_nxt[i] = 1'b0;
      end else begin
        case (r_state[i])
          ST_WAIT: begin
            if (w_expire[i]) begin
              // Expiry wins over a same-cycle ack: notif stays set.
              w_notif_nxt[i] = 1'b1;
              if (r_mode[i]) begin
                w_cnt_nxt[i] = r_rld[i];
                if (w_ack_hit[i])
                  w_missed_nxt[i] = 1'b0;
                else if (r_notif[i])
                  w_missed_nxt[i] = 1'b1;
              end else begin
                w_state_nxt[i] = ST_PEND;
              end
            end else begin
              if (r_cnt[i] > CW'(1))
                w_cnt_nxt[i] = r_cnt[i] - CW'(1);
              if (w_ack_hit[i]) begin
                w_notif_nxt[i]  = 1'b0;
                w_missed_nxt[i] = 1'b0;
              end
            end
          end
          ST_PEND: begin
            if (w_ack_hit[i]) begin
              w_state_nxt[i]  = ST_IDLE;
              w_notif_nxt[i]  = 1'b0;
              w_missed_nxt[i] = 1'b0;
            end
          end
          default: ;
        endcase
      end
      w_busy_nxt[i] = (w_state_nxt[i] != ST_IDLE);
    end
    w_irq_nxt = |(w_notif_nxt & ~r_notif);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
        r_rld[i]   <= '0;
      end
      r_mode   <= '0;
      r_notif  <= '0;
      r_missed <= '0;
      r_busy   <= '0;
      r_irq    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_rld[i]   <= w_rld_nxt[i];
      end
      r_mode   <= w_mode_nxt;
      r_notif  <= w_notif_nxt;
      r_missed <= w_missed_nxt;
      r_busy   <= w_busy_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  // Lowest pending channel wins.
  always_comb begin
    alert_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_notif[i])
        alert_ch = IDW'(i);
    end
  end

  assign alert_valid = |r_notif;
  assign busy        = r_busy;
  assign notif       = r_notif;
  assign missed      = r_missed;
  assign irq         = r_irq;

endmodule

// File: tb/tb_multi_rem_sys.sv
// Testbench for multi_rem_sys: directed scenarios plus randomized traffic,
// all compared against an absolute-time reference model.
module tb_multi_rem_sys;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned IDW = 2;
  localparam int unsigned OW  = 3 * NCH + 2 + IDW;

  logic           clk = 1'b0;
  logic           rst;
  logic           set;
  logic [IDW-1:0] set_ch;
  logic [CW-1:0]  dur;
  logic           periodic;
  logic           cancel;
  logic [IDW-1:0] cancel_ch;
  logic           ack;
  logic [IDW-1:0] ack_ch;
  logic [NCH-1:0] busy, notif, missed;
  logic           irq, alert_valid;
  logic [IDW-1:0] alert_ch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_rem_sys #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .set(set), .set_ch(set_ch), .dur(dur), .periodic(periodic),
    .cancel(cancel), .cancel_ch(cancel_ch),
    .ack(ack), .ack_ch(ack_ch),
    .busy(busy), .notif(notif), .missed(missed), .irq(irq),
    .alert_valid(alert_valid), .alert_ch(alert_ch)
  );

  // Reference model: each armed channel remembers the absolute edge of its next expiry.
  bit             m_wait   [NCH];
  bit             m_pend   [NCH];
  bit             m_per    [NCH];
  longint         m_due    [NCH];
  longint         m_period [NCH];
  logic [NCH-1:0] m_notif, m_missed;
  logic           m_irq;
  longint         t_edge = 0;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_wait[i] = 0; m_pend[i] = 0; m_per[i] = 0; m_due[i] = 0; m_period[i] = 0;
    end
    m_notif = '0; m_missed = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] prev;
    bit c, s, a;
    prev = m_notif;
    t_edge++;
    for (int i = 0; i < NCH; i++) begin
      c = cancel && (cancel_ch == IDW'(i));
      s = set && (set_ch == IDW'(i)) && (dur != 0);
      a = ack && (ack_ch == IDW'(i));
      if (c) begin
        m_wait[i] = 0; m_pend[i] = 0; m_notif[i] = 1'b0; m_missed[i] = 1'b0;
      end else if (s) begin
        m_wait[i] = 1; m_pend[i] = 0; m_per[i] = periodic;
        m_period[i] = longint'(dur);
        m_due[i] = t_edge + longint'(dur);
        m_notif[i] = 1'b0; m_missed[i] = 1'b0;
      end else if (m_wait[i] && m_due[i] == t_edge) begin
        if (m_per[i]) begin
          m_missed[i] = a ? 1'b0 : (m_missed[i] | m_notif[i]);
          m_due[i] = m_due[i] + m_period[i];
        end else begin
          m_wait[i] = 0; m_pend[i] = 1;
        end
        m_notif[i] = 1'b1;
      end else if (a && (m_wait[i] || m_pend[i])) begin
        m_notif[i] = 1'b0; m_missed[i] = 1'b0; m_pend[i] = 0;
      end
    end
    m_irq = |(m_notif & ~prev);
  endtask

  function automatic logic [OW-1:0] obs_vec();
    return {busy, notif, missed, irq, alert_valid, alert_ch};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic [NCH-1:0] b;
    logic [IDW-1:0] ac;
    ac = '0;
    for (int i = 0; i < NCH; i++) b[i] = m_wait[i] | m_pend[i];
    for (int i = 0; i < NCH; i++) begin
      if (m_notif[i]) begin
        ac = IDW'(i);
        break;
      end
    end
    return {b, m_notif, m_missed, m_irq, |m_notif, ac};
  endfunction

  task automatic idle_inputs();
    set = 1'b0; cancel = 1'b0; ack = 1'b0;
  endtask

  // One clock edge: model follows the DUT's sampled inputs, outputs read 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  task automatic arm(input int ch, input int d, input bit p);
    set = 1'b1; set_ch = IDW'(ch); dur = CW'(d); periodic = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_ch = '0; dur = '0; periodic = 1'b0; cancel_ch = '0; ack_ch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", obs_vec());
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_oneshot();
    arm(0, 5, 1'b0);
    cyc();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL oneshot_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k == 4) begin
        checks++;
        if (notif[0] !== 1'b0) begin
          failures++;
          $display("FAIL oneshot_early got=%b exp=0", notif[0]);
        end
      end
      if (k == 5) begin
        checks++;
        if ({notif[0], irq, alert_valid, alert_ch} !== {1'b1, 1'b1, 1'b1, 2'd0}) begin
          failures++;
          $display("FAIL oneshot_expiry got=%b%b%b%0d exp=1110", notif[0], irq, alert_valid, alert_ch);
        end
      end
      if (k == 6) begin
        checks++;
        if (irq !== 1'b0) begin
          failures++;
          $display("FAIL oneshot_irq_pulse got=%b exp=0", irq);
        end
      end
    end
    ack = 1'b1; ack_ch = 2'd0;
    cyc();
    checks++;
    if ({notif[0], busy[0]} !== 2'b00 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL oneshot_ack got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_periodic();
    arm(2, 3, 1'b1);
    cyc();
    for (int k = 1; k <= 9; k++) begin
      if (k == 7) begin ack = 1'b1; ack_ch = 2'd2; end
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL periodic_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k == 3 || k == 6 || k == 7 || k == 9) begin
        logic [1:0] want;
        want = (k == 3) ? 2'b10 : (k == 6) ? 2'b11 : (k == 7) ? 2'b00 : 2'b10;
        checks++;
        if ({notif[2], missed[2]} !== want) begin
          failures++;
          $display("FAIL periodic_flags k=%0d got=%b%b exp=%b", k, notif[2], missed[2], want);
        end
      end
    end
    cancel = 1'b1; cancel_ch = 2'd2;
    cyc();
    checks++;
    if (busy[2] !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL periodic_cancel got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_priority();
    arm(1, 4, 1'b0);
    cyc();
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) arm(3, 2, 1'b0);
      if (k == 5) begin ack = 1'b1; ack_ch = 2'd1; end
      if (k == 6) begin ack = 1'b1; ack_ch = 2'd3; end
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL priority_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k >= 3) begin
        logic [2:0] want;
        want = (k == 4) ? 3'b101 : (k == 6) ? 3'b000 : 3'b111;
        checks++;
        if ({alert_valid, alert_ch} !== want) begin
          failures++;
          $display("FAIL priority_alert k=%0d got=%b%0d exp=%b", k, alert_valid, alert_ch, want);
        end
      end
    end
  endtask

  task automatic test_ignored_rearm();
    arm(0, 0, 1'b1);
    cyc();
    checks++;
    if (busy !== '0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL ignore_dur0 got=%h exp=%h", obs_vec(), exp_vec());
    end
    arm(0, 5, 1'b0);
    cyc();
    for (int k = 1; k <= 11; k++) begin
      if (k == 3) arm(0, 8, 1'b0);
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rearm_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k == 5 || k == 10 || k == 11) begin
        checks++;
        if (notif[0] !== (k == 11)) begin
          failures++;
          $display("FAIL rearm_expiry k=%0d got=%b exp=%b", k, notif[0], (k == 11));
        end
      end
    end
    ack = 1'b1; ack_ch = 2'd0;
    cyc();
  endtask

  task automatic test_same_cycle();
    arm(1, 4, 1'b1);
    cyc();
    cyc();
    cancel = 1'b1; cancel_ch = 2'd1;
    arm(1, 6, 1'b1);
    ack = 1'b1; ack_ch = 2'd1;
    cyc();
    checks++;
    if (busy[1] !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL same_cycle_cancel got=%h exp=%h", obs_vec(), exp_vec());
    end
    arm(1, 3, 1'b1);
    cyc();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin ack = 1'b1; ack_ch = 2'd1; end
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL same_cycle_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({notif[1], missed[1]} !== 2'b10) begin
      failures++;
      $display("FAIL ack_on_expiry got=%b%b exp=10", notif[1], missed[1]);
    end
    cancel = 1'b1; cancel_ch = 2'd1;
    cyc();
  endtask

  task automatic test_reset_midcount();
    arm(0, 10, 1'b0);
    cyc();
    arm(2, 6, 1'b1);
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", obs_vec());
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({busy, notif} !== '0) begin
      failures++;
      $display("FAIL reset_no_notif got=%b%b exp=0", busy, notif);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      set       = ($urandom_range(0, 3) == 0);
      set_ch    = IDW'($urandom_range(0, NCH - 1));
      dur       = CW'($urandom_range(0, 10));
      periodic  = 1'($urandom_range(0, 1));
      cancel    = ($urandom_range(0, 11) == 0);
      cancel_ch = IDW'($urandom_range(0, NCH - 1));
      ack       = ($urandom_range(0, 2) == 0);
      ack_ch    = IDW'($urandom_range(0, NCH - 1));
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_priority();
    test_ignored_rearm();
    test_same_cycle();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
